// File: rtl/iterative_booth_multiplier_pkg.sv
// Shared encodings for the iterative radix-4 Booth multiplier: FSM states,
// Booth digit select codes and the digit decode helper.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } booth_digit_e;

   // Map a multiplier triplet {b[2i+1], b[2i], b[2i-1]} to its Booth digit.
   function automatic booth_digit_e booth_decode(input logic [2:0] bits);
      booth_digit_e dig;
      case (bits)
         3'b000, 3'b111: dig = ZERO;
         3'b001, 3'b010: dig = POS1;
         3'b011:         dig = POS2;
         3'b100:         dig = NEG2;
         3'b101, 3'b110: dig = NEG1;
         default:        dig = ZERO;
      endcase
      return dig;
   endfunction

endpackage

// File: rtl/iterative_booth_multiplier_if.sv
// Operand/result handshake bundle between the issuing FSM and the multiplier.
interface iterative_booth_multiplier_if #(
   parameter int WIDTH = 8
);
   logic               Start;
   logic               Signed_Mode;
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic               Busy;
   logic               Done;
   logic [2*WIDTH-1:0] Result;

   modport master (
      output Start, Signed_Mode, A, B,
      input  Busy, Done, Result
   );

   modport slave (
      input  Start, Signed_Mode, A, B,
      output Busy, Done, Result
   );
endinterface

// File: rtl/iterative_booth_multiplier_digit.sv
// Combinational radix-4 Booth digit: turns one multiplier triplet and the
// extended multiplicand into a signed partial product of WIDTH+3 bits.
module booth_radix4_digit
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       bits,
   input  logic [WIDTH+1:0] mcand,
   output logic [WIDTH+2:0] pp
);

   logic [WIDTH+2:0] m1_s;
   logic [WIDTH+2:0] m2_s;

   assign m1_s = {mcand[WIDTH+1], mcand};
   assign m2_s = {mcand, 1'b0};

   // Select the multiple of M chosen by the digit.
   always_comb begin
      pp = {(WIDTH+3){1'b0}};
      case (booth_decode(bits))
         ZERO:    pp = {(WIDTH+3){1'b0}};
         POS1:    pp = m1_s;
         POS2:    pp = m2_s;
         NEG1:    pp = -m1_s;
         NEG2:    pp = -m2_s;
         default: pp = {(WIDTH+3){1'b0}};
      endcase
   end

endmodule

// File: rtl/iterative_booth_multiplier.sv
// Multi-cycle radix-4 Booth multiplier: one digit per cycle over ITER cycles,
// start/done handshake, signed or unsigned operands selected per operation.
module iterative_booth_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                         CLK,
   input logic                         RSTn,
   iterative_booth_multiplier_if.slave bus
);

   localparam int ITER = (WIDTH / 2) + 1;
   localparam int CW   = $clog2(ITER + 1);
   localparam int AW   = 2 * WIDTH + 4;
   localparam logic [CW-1:0] LAST_COUNT = CW'(ITER - 1);

   state_e             state_r;
   logic [CW-1:0]      count_r;
   logic [WIDTH+1:0]   mcand_r;
   logic [WIDTH+1:0]   mplier_r;
   logic               prev_r;
   logic [AW-1:0]      acc_r;
   logic [2*WIDTH-1:0] result_r;
   logic               busy_r;
   logic               done_r;

   logic [WIDTH+1:0]   a_ext_s;
   logic [WIDTH+1:0]   b_ext_s;
   logic [WIDTH+2:0]   pp_s;
   logic [AW-1:0]      pp_ext_s;
   logic [CW:0]        shamt_s;
   logic [AW-1:0]      acc_sum_s;

   // Two extra bits let the top digit see the sign (or a zero) above the operand.
   assign a_ext_s = bus.Signed_Mode ? {{2{bus.A[WIDTH-1]}}, bus.A} : {2'b00, bus.A};
   assign b_ext_s = bus.Signed_Mode ? {{2{bus.B[WIDTH-1]}}, bus.B} : {2'b00, bus.B};

   booth_radix4_digit #(.WIDTH(WIDTH)) u_digit (
      .bits  ({mplier_r[1:0], prev_r}),
      .mcand (mcand_r),
      .pp    (pp_s)
   );

   assign pp_ext_s  = {{(AW-WIDTH-3){pp_s[WIDTH+2]}}, pp_s};
   assign shamt_s   = {count_r, 1'b0};
   assign acc_sum_s = acc_r + (pp_ext_s << shamt_s);

   assign bus.Busy   = busy_r;
   assign bus.Done   = done_r;
   assign bus.Result = result_r;

   // Control FSM with datapath registers; outputs are registered alongside state.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_r  <= IDLE;
         count_r  <= {CW{1'b0}};
         mcand_r  <= {(WIDTH+2){1'b0}};
         mplier_r <= {(WIDTH+2){1'b0}};
         prev_r   <= 1'b0;
         acc_r    <= {AW{1'b0}};
         result_r <= {(2*WIDTH){1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.Start) begin
                  mcand_r  <= a_ext_s;
                  mplier_r <= b_ext_s;
                  prev_r   <= 1'b0;
                  acc_r    <= {AW{1'b0}};
                  count_r  <= {CW{1'b0}};
                  busy_r   <= 1'b1;
                  state_r  <= CALC;
               end else begin
                  busy_r   <= 1'b0;
               end
            end
            CALC: begin
               acc_r    <= acc_sum_s;
               mplier_r <= {2'b00, mplier_r[WIDTH+1:2]};
               prev_r   <= mplier_r[1];
               count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
               // The final digit's sum goes straight to Result so Done and data align.
               if (count_r == LAST_COUNT) begin
                  result_r <= acc_sum_s[2*WIDTH-1:0];
                  done_r   <= 1'b1;
                  state_r  <= DONE;
               end else begin
                  done_r   <= 1'b0;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iterative_booth_multiplier.sv
// Directed and random checks of the iterative Booth multiplier at WIDTH=8 and WIDTH=16.
module tb_iterative_booth_multiplier;

   logic CLK  = 1'b0;
   logic RSTn = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 CLK = ~CLK;

   iterative_booth_multiplier_if #(.WIDTH(8))  bus8 ();
   iterative_booth_multiplier_if #(.WIDTH(16)) bus16 ();

   iterative_booth_multiplier #(.WIDTH(8))  dut8  (.CLK(CLK), .RSTn(RSTn), .bus(bus8));
   iterative_booth_multiplier #(.WIDTH(16)) dut16 (.CLK(CLK), .RSTn(RSTn), .bus(bus16));

   typedef struct {
      bit          wide;
      bit          sm;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_prod(input bit wide, input bit sm,
                                            input logic [15:0] a, input logic [15:0] b);
      longint sa, sb, p;
      if (wide) begin
         sa = sm ? longint'($signed(a)) : longint'(a);
         sb = sm ? longint'($signed(b)) : longint'(b);
         p  = sa * sb;
         return p[31:0];
      end else begin
         sa = sm ? longint'($signed(a[7:0])) : longint'(a[7:0]);
         sb = sm ? longint'($signed(b[7:0])) : longint'(b[7:0]);
         p  = sa * sb;
         return {16'h0000, p[15:0]};
      end
   endfunction

   // Issue one operation at the next negedge; report Done cycle (-1 if none) and Busy drops.
   task automatic do_op(input bit wide, input bit sm, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] res, output int dcyc, output int busy_err);
      logic bsy, dn;
      logic [31:0] r;
      dcyc = -1; busy_err = 0; res = 32'h0;
      @(negedge CLK);
      if (wide) begin
         bus16.Start = 1'b1; bus16.Signed_Mode = sm; bus16.A = a; bus16.B = b;
      end else begin
         bus8.Start = 1'b1; bus8.Signed_Mode = sm; bus8.A = a[7:0]; bus8.B = b[7:0];
      end
      for (int c = 1; c <= 20 && dcyc < 0; c++) begin
         @(negedge CLK);
         if (c == 1) begin
            if (wide) bus16.Start = 1'b0;
            else      bus8.Start  = 1'b0;
         end
         if (wide) begin
            bsy = bus16.Busy; dn = bus16.Done; r = bus16.Result;
         end else begin
            bsy = bus8.Busy; dn = bus8.Done; r = {16'h0000, bus8.Result};
         end
         if (bsy !== 1'b1) busy_err++;
         if (dn === 1'b1) begin
            dcyc = c;
            res  = r;
         end
      end
   endtask

   initial begin
      logic [31:0] res;
      int dcyc, berr, ndone, d1, d2;
      logic [31:0] r1, r2;

      vecs[0]  = '{1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01};
      vecs[1]  = '{1'b0, 1'b1, 16'h0080, 16'h0080, 32'h00004000};
      vecs[2]  = '{1'b0, 1'b1, 16'h00FF, 16'h007F, 32'h0000FF81};
      vecs[3]  = '{1'b0, 1'b1, 16'h00FE, 16'h0002, 32'h0000FFFC};
      vecs[4]  = '{1'b0, 1'b0, 16'h00FE, 16'h0002, 32'h000001FC};
      vecs[5]  = '{1'b0, 1'b0, 16'h0003, 16'h0005, 32'h0000000F};
      vecs[6]  = '{1'b0, 1'b1, 16'h007F, 16'h0081, 32'h0000C0FF};
      vecs[7]  = '{1'b0, 1'b1, 16'h0080, 16'h007F, 32'h0000C080};
      vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h00FF, 32'h00000000};
      vecs[9]  = '{1'b1, 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000};
      vecs[10] = '{1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};

      bus8.Start = 1'b0;  bus8.Signed_Mode = 1'b0;  bus8.A = 8'h00;  bus8.B = 8'h00;
      bus16.Start = 1'b0; bus16.Signed_Mode = 1'b0; bus16.A = 16'h0; bus16.B = 16'h0;
      #22 RSTn = 1'b1;

      @(negedge CLK);
      check("rst_busy8", {31'd0, bus8.Busy}, 32'd0);
      check("rst_done8", {31'd0, bus8.Done}, 32'd0);
      check("rst_res8", {16'h0, bus8.Result}, 32'd0);
      check("rst_busy16", {31'd0, bus16.Busy}, 32'd0);
      check("rst_res16", bus16.Result, 32'd0);

      for (int i = 0; i < 11; i++) begin
         do_op(vecs[i].wide, vecs[i].sm, vecs[i].a, vecs[i].b, res, dcyc, berr);
         check($sformatf("vec%0d_res", i), res, vecs[i].exp);
         check($sformatf("vec%0d_cyc", i), dcyc, vecs[i].wide ? 32'd10 : 32'd6);
         check($sformatf("vec%0d_busy", i), berr, 32'd0);
      end

      // Start re-asserted during CALC is ignored; next Start right after Done is taken.
      ndone = 0; d1 = -1; d2 = -1; r1 = 32'h0; r2 = 32'h0;
      @(negedge CLK);
      bus8.Start = 1'b1; bus8.Signed_Mode = 1'b0; bus8.A = 8'd3; bus8.B = 8'd5;
      for (int c = 1; c <= 16; c++) begin
         @(negedge CLK);
         if (bus8.Done === 1'b1) begin
            ndone++;
            if (ndone == 1) begin d1 = c; r1 = {16'h0, bus8.Result}; end
            else            begin d2 = c; r2 = {16'h0, bus8.Result}; end
         end
         if (c == 1 || c == 4 || c == 8) bus8.Start = 1'b0;
         if (c == 3 || c == 7) begin
            bus8.Start = 1'b1; bus8.A = 8'd7; bus8.B = 8'd7;
         end
      end
      check("ign_ndone", ndone, 32'd2);
      check("ign_cyc1", d1, 32'd6);
      check("ign_res1", r1, 32'h000F);
      check("ign_cyc2", d2, 32'd13);
      check("ign_res2", r2, 32'h0031);

      // Start held high restarts on every IDLE visit.
      ndone = 0; d1 = -1; d2 = -1;
      @(negedge CLK);
      bus8.Start = 1'b1; bus8.Signed_Mode = 1'b0; bus8.A = 8'hFF; bus8.B = 8'hFF;
      for (int c = 1; c <= 14; c++) begin
         @(negedge CLK);
         if (bus8.Done === 1'b1) begin
            ndone++;
            if (ndone == 1) d1 = c;
            else            d2 = c;
         end
      end
      bus8.Start = 1'b0;
      check("hold_ndone", ndone, 32'd2);
      check("hold_cyc1", d1, 32'd6);
      check("hold_cyc2", d2, 32'd13);
      check("hold_res", {16'h0, bus8.Result}, 32'hFE01);

      // Reset in cycle 3 of an operation clears everything and suppresses Done.
      ndone = 0;
      @(negedge CLK);
      bus8.Start = 1'b1; bus8.A = 8'h10; bus8.B = 8'h10;
      @(negedge CLK);
      bus8.Start = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("mid_busy_pre", {31'd0, bus8.Busy}, 32'd1);
      RSTn = 1'b0;
      #1;
      check("mid_busy", {31'd0, bus8.Busy}, 32'd0);
      check("mid_res", {16'h0, bus8.Result}, 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RSTn = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         if (bus8.Done === 1'b1) ndone++;
      end
      check("mid_nodone", ndone, 32'd0);
      do_op(1'b0, 1'b0, 16'h0010, 16'h0010, res, dcyc, berr);
      check("mid_fresh_res", res, 32'h0100);
      check("mid_fresh_cyc", dcyc, 32'd6);

      // Random operands per mode on both widths in parallel, against a native product.
      fork
         begin
            logic [31:0] rr; int rc, rb; logic [15:0] ra, rbv; bit sm;
            for (int i = 0; i < 4000; i++) begin
               sm = (i >= 2000); ra = 16'($urandom); rbv = 16'($urandom);
               do_op(1'b0, sm, ra, rbv, rr, rc, rb);
               check("rand8", rr, ref_prod(1'b0, sm, ra, rbv));
            end
         end
         begin
            logic [31:0] rr; int rc, rb; logic [15:0] ra, rbv; bit sm;
            for (int i = 0; i < 4000; i++) begin
               sm = (i >= 2000); ra = 16'($urandom); rbv = 16'($urandom);
               do_op(1'b1, sm, ra, rbv, rr, rc, rb);
               check("rand16", rr, ref_prod(1'b1, sm, ra, rbv));
            end
         end
      join

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
